// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the 1RW SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        INIT       = 2'd0,
        RUN        = 2'd1,
        FLUSH_WAIT = 2'd2
    } arb_state_e;

    localparam int REQ_REFILL = 0;
    localparam int REQ_CORE   = 1;

    // Bits covered by one write-mask lane.
    function automatic int lane_width(input int data_w, input int mask_w);
        return data_w / mask_w;
    endfunction

    function automatic bit lanes_ok(input int data_w, input int mask_w);
        return (mask_w > 0) && (data_w % mask_w == 0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; pointer favours the port that lost the last grant.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
            else                grant = valid;
        end
    end

    // A grant always fires, so the winner hands priority to the other port.
    always_ff @(posedge clock) begin
        if (reset)       ptr <= 1'b0;
        else if (|grant) ptr <= grant[0];
    end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// Shares one 1RW SRAM between refill (port 0) and core (port 1) requesters,
// zero-sweeping the array after reset and on flush.
module sram_1rw_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 256,
    parameter int MASK_W        = 32,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*MASK_W-1:0]   req_wmask,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    input  logic                  flush_req,
    output logic                  init_done,
    output logic                  mem_en,
    output logic                  mem_wmode,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [MASK_W-1:0]     mem_wmask,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    arb_state_e        state, state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic [1:0]        grant, resp_q;
    logic              arb_en, sel;

    logic [ADDR_W-1:0] addr_a [2];
    logic [MASK_W-1:0] mask_a [2];
    logic [DATA_W-1:0] data_a [2];

    for (genvar k = 0; k < 2; k++) begin : g_split
        assign addr_a[k] = req_addr [k*ADDR_W +: ADDR_W];
        assign mask_a[k] = req_wmask[k*MASK_W +: MASK_W];
        assign data_a[k] = req_wdata[k*DATA_W +: DATA_W];
    end

    // A flush cycle grants nothing so the sweep never races a live request.
    assign arb_en = (state == RUN) && !flush_req && !reset;

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .valid  (req_valid),
        .enable (arb_en),
        .grant  (grant)
    );

    assign req_ready  = grant;
    assign sel        = grant[REQ_CORE];
    assign resp_valid = resp_q;
    assign resp_rdata = mem_rdata;

    always_comb begin
        state_nxt = state;
        init_done = 1'b0;
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        case (state)
            INIT: begin
                mem_en    = 1'b1;
                mem_wmode = 1'b1;
                mem_addr  = init_cnt;
                mem_wmask = '1;
                if (init_cnt == '1) state_nxt = RUN;
            end
            RUN: begin
                init_done = 1'b1;
                if (|grant) begin
                    mem_en    = 1'b1;
                    mem_wmode = req_write[sel];
                    mem_addr  = addr_a[sel];
                    mem_wmask = mask_a[sel];
                    mem_wdata = data_a[sel];
                end
                if (flush_req) state_nxt = FLUSH_WAIT;
            end
            FLUSH_WAIT: state_nxt = INIT;
            default:    state_nxt = INIT;
        endcase
        if (reset) begin
            mem_en    = 1'b0;
            init_done = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= (INIT_ON_RESET != 0) ? INIT : RUN;
            init_cnt <= '0;
            resp_q   <= 2'b00;
        end else begin
            state    <= state_nxt;
            init_cnt <= (state == INIT) ? init_cnt + 1'b1 : '0;
            resp_q   <= grant & ~req_write;
        end
    end

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Randomised and directed bench for sram_1rw_arbiter with a behavioural SRAM
// and a reference model of array contents, arbitration and responses.
module tb_sram_1rw_arbiter;

    localparam int AW    = 9;
    localparam int DW    = 256;
    localparam int MW    = 32;
    localparam int LW    = DW / MW;
    localparam int DEPTH = 1 << AW;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      req_valid, req_ready, req_write, resp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*MW-1:0] req_wmask;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0]   resp_rdata, mem_wdata, mem_rdata;
    logic            flush_req, init_done, mem_en, mem_wmode;
    logic [AW-1:0]   mem_addr;
    logic [MW-1:0]   mem_wmask;

    always #5 clock = ~clock;

    sram_1rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .INIT_ON_RESET(1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wmask(req_wmask),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .flush_req(flush_req), .init_done(init_done), .mem_en(mem_en),
        .mem_wmode(mem_wmode), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int j = 0; j < DW/32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural macro: never-written rows read back as junk.
    logic [DW-1:0] sram [DEPTH];
    bit            wr_seen [DEPTH];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_wmode) begin
                if (!wr_seen[mem_addr]) sram[mem_addr] <= rnd_data();
                for (int i = 0; i < MW; i++)
                    if (mem_wmask[i]) sram[mem_addr][i*LW +: LW] <= mem_wdata[i*LW +: LW];
                wr_seen[mem_addr] <= mem_wmask == '1 ? 1'b1 : wr_seen[mem_addr];
            end else begin
                mem_rdata <= wr_seen[mem_addr] ? sram[mem_addr] : rnd_data();
            end
        end
    end

    bit [DW-1:0] ref_mem [DEPTH];
    bit          fav;
    bit [1:0]    pend_rv;
    bit [DW-1:0] pend_rd;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  g;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 2'b00; req_write = 2'b00; req_addr = '0;
        req_wmask = '0;    req_wdata = '0;    flush_req = 1'b0;
    endtask

    // n cycles of the zero sweep, starting at address 0.
    task automatic sweep_check(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 2'($urandom);
            req_write = 2'($urandom);
            flush_req = ($urandom_range(0, 15) == 0);
            #2;
            chk("sweep_ctl", DW'({mem_en, mem_wmode, req_ready, init_done, resp_valid, mem_addr}),
                DW'({1'b1, 1'b1, 2'b00, 1'b0, 2'b00, AW'(i)}));
            chk("sweep_mask", DW'(mem_wmask), DW'({MW{1'b1}}));
            chk("sweep_data", mem_wdata, '0);
            tick();
        end
        if (n == DEPTH) foreach (ref_mem[a]) ref_mem[a] = '0;
        idle_inputs();
    endtask

    // One RUN cycle; checks against the model and returns the observed req_ready.
    task automatic run_cycle(input logic [1:0] v, input logic [1:0] w,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input bit fl, output logic [1:0] g_obs);
        logic [1:0]    exp_g;
        int            k;
        logic [AW-1:0] a;
        logic [MW-1:0] m;
        logic [DW-1:0] d;
        req_valid = v; req_write = w; req_addr = {a1, a0};
        req_wmask = {m1, m0}; req_wdata = {d1, d0}; flush_req = fl;
        #2;
        if (fl)            exp_g = 2'b00;
        else if (v == 2'b11) exp_g = fav ? 2'b10 : 2'b01;
        else               exp_g = v;
        chk("ready", DW'(req_ready), DW'(exp_g));
        chk("init_done", DW'(init_done), DW'(1'b1));
        chk("resp_valid", DW'(resp_valid), DW'(pend_rv));
        if (pend_rv != 2'b00) chk("resp_rdata", resp_rdata, pend_rd);
        chk("mem_en", DW'(mem_en), DW'(|exp_g));
        pend_rv = 2'b00;
        if (exp_g != 2'b00) begin
            k = exp_g[1] ? 1 : 0;
            a = k ? a1 : a0; m = k ? m1 : m0; d = k ? d1 : d0;
            fav = (k == 0);
            chk("mem_addr", DW'(mem_addr), DW'(a));
            chk("mem_wmode", DW'(mem_wmode), DW'(w[k]));
            if (w[k]) begin
                chk("mem_wmask", DW'(mem_wmask), DW'(m));
                chk("mem_wdata", mem_wdata, d);
                for (int i = 0; i < MW; i++)
                    if (m[i]) ref_mem[a][i*LW +: LW] = d[i*LW +: LW];
            end else begin
                pend_rv[k] = 1'b1;
                pend_rd    = ref_mem[a];
            end
        end
        g_obs = req_ready;
        tick();
    endtask

    task automatic req1(input int p, input bit w, input logic [AW-1:0] a,
                        input logic [MW-1:0] m, input logic [DW-1:0] d);
        logic [1:0] go;
        if (p == 0) run_cycle(2'b01, {1'b0, w}, a, '0, m, '0, d, '0, 1'b0, go);
        else        run_cycle(2'b10, {w, 1'b0}, '0, a, '0, m, '0, d, 1'b0, go);
    endtask

    task automatic idle_cycle();
        logic [1:0] go;
        run_cycle(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 1'b0, go);
    endtask

    task automatic rand_cycles(input int n);
        logic [1:0] go;
        for (int i = 0; i < n; i++)
            run_cycle(2'($urandom), 2'($urandom), AW'($urandom_range(0, 7)),
                      AW'($urandom_range(0, 7)), MW'($urandom), MW'($urandom),
                      rnd_data(), rnd_data(), 1'b0, go);
    endtask

    localparam logic [DW-1:0] PAT = {8{32'hDEADBEEF}};

    initial begin
        idle_inputs();
        reset = 1'b1;
        req_valid = 2'b11;
        repeat (3) tick();
        #2;
        chk("rst_outputs", DW'({req_ready, resp_valid, mem_en, init_done}), '0);
        tick();
        reset = 1'b0;
        idle_inputs();
        fav = 1'b0; pend_rv = 2'b00;
        sweep_check(DEPTH);

        // Write then read back on the core port.
        req1(1, 1'b1, AW'('h1A5), '1, PAT);
        req1(1, 1'b0, AW'('h1A5), '0, '0);
        #2;
        chk("raw_resp_valid", DW'(resp_valid), DW'(2'b10));
        chk("raw_rdata", resp_rdata, PAT);
        idle_cycle();

        // Both ports reading continuously alternate grants.
        for (int i = 0; i < 6; i++) begin
            run_cycle(2'b11, 2'b00, AW'($urandom), AW'($urandom), '0, '0, '0, '0, 1'b0, g);
            chk("alternate", DW'(g), DW'((i % 2) ? 2'b10 : 2'b01));
        end
        idle_cycle();

        // Single-lane write over swept zeros.
        req1(0, 1'b1, AW'(3), MW'(1), '1);
        req1(0, 1'b0, AW'(3), '0, '0);
        #2;
        chk("mask_rdata", resp_rdata, DW'(8'hFF));
        idle_cycle();

        rand_cycles(300);

        // Flush right after a read fire.
        req1(0, 1'b1, AW'(5), '1, PAT);
        req1(1, 1'b0, AW'(5), '0, '0);
        run_cycle(2'b11, 2'b00, AW'(5), AW'(5), '0, '0, '0, '0, 1'b1, g);
        req_valid = 2'b11;
        #2;
        chk("fw_ctl", DW'({req_ready, init_done, mem_en, resp_valid}), '0);
        tick();
        pend_rv = 2'b00;
        sweep_check(DEPTH);
        req1(1, 1'b0, AW'(5), '0, '0);
        #2;
        chk("post_flush_rdata", resp_rdata, '0);
        idle_cycle();
        rand_cycles(50);

        // Reset in the middle of a sweep with a request pending.
        run_cycle(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, 1'b1, g);
        tick();
        sweep_check(200);
        reset = 1'b1;
        req_valid = 2'b11;
        #2;
        chk("midrst_comb", DW'({req_ready, mem_en, init_done}), '0);
        tick();
        #2;
        chk("midrst_regs", DW'({req_ready, resp_valid, mem_en, init_done}), '0);
        tick();
        reset = 1'b0;
        idle_inputs();
        fav = 1'b0; pend_rv = 2'b00;
        sweep_check(DEPTH);
        rand_cycles(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_1rw_arbiter.md
Name: sram_1rw_arbiter

Overview:
- Sequencer/arbiter that shares one single-port 1RW SRAM macro (1-cycle read latency, byte/lane write mask; e.g. 512x256 data array, 64x88 tag array) between two requesters.
- Port 0 is the refill/writeback side; port 1 is the core-access side.
- After reset, and on flush request, it sweeps the whole array writing zeros so that no random macro contents are ever visible.
- Sits between the cache control logic and the *_ext SRAM instance.

Parameters:
- ADDR_W, 9, SRAM address width; depth = 2^ADDR_W.
- DATA_W, 256, SRAM data width.
- MASK_W, 32, write-mask lanes; DATA_W is divisible by MASK_W.
- INIT_ON_RESET, 1, 1 = zero-sweep after reset; 0 = go straight to RUN.

Ports:
- clock  in  1  sole clock; also drives the SRAM clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  per-requester request valid ([0] = port 0).
- req_ready  out  2  per-requester accept; at most one bit high.
- req_write  in  2  1 = write, 0 = read.
- req_addr  in  2*ADDR_W  packed addresses, port 0 in LSBs.
- req_wmask  in  2*MASK_W  packed write masks.
- req_wdata  in  2*DATA_W  packed write data.
- resp_valid  out  2  read data valid, one per port; no backpressure.
- resp_rdata  out  DATA_W  read data, shared by both ports.
- flush_req  in  1  pulse: re-zero the whole array.
- init_done  out  1  high in RUN.
- mem_en  out  1  SRAM RW0 enable.
- mem_wmode  out  1  SRAM RW0 write mode.
- mem_addr  out  ADDR_W  SRAM RW0 address.
- mem_wmask  out  MASK_W  SRAM RW0 write mask.
- mem_wdata  out  DATA_W  SRAM RW0 write data.
- mem_rdata  in  DATA_W  SRAM RW0 read data.

Behaviour:
- Reset values:
  - state = INIT if INIT_ON_RESET, else RUN.
  - init counter = 0; rr pointer = 0 (port 0 favoured).
  - req_ready, resp_valid, mem_en, init_done = 0.
- FSM states: INIT, RUN, FLUSH_WAIT.
- INIT:
  - Each cycle: mem_en = 1, mem_wmode = 1, mem_addr = counter, mem_wmask = all ones, mem_wdata = 0.
  - Counter increments each cycle. At counter = 2^ADDR_W-1 that write issues, then state goes to RUN; no wrap re-sweep.
  - Sweep length is exactly 2^ADDR_W cycles.
  - req_ready = 0 throughout. flush_req is ignored.
- RUN:
  - init_done = 1.
  - mem_* is driven combinationally from the granted request in the same cycle; fire = req_valid[k] & req_ready[k].
  - mem_en = 0 when neither port fires.
- Arbitration:
  - Only one valid: that port gets ready.
  - Both valid: the port selected by the rr pointer gets ready.
  - On any fire, the pointer moves to the non-granted port.
  - req_ready never depends combinationally on req_write or req_addr; it depends only on req_valid, the pointer and state.
- Read response:
  - A read fire at cycle N gives resp_valid[k] = 1 at N+1 only, with resp_rdata = mem_rdata.
  - resp_rdata is don't-care when no resp_valid is set.
- Writes produce no response.
- Ordering:
  - Single port, strictly in order.
  - A read in the cycle after a write to the same address returns the new data.
  - Write mask lane i covers bits [(i+1)*DATA_W/MASK_W-1 : i*DATA_W/MASK_W].
- flush_req high in RUN:
  - That cycle has no grants (req_ready = 0).
  - A response owed from cycle N-1 is still delivered.
  - Next state is FLUSH_WAIT for one cycle (init_done = 0), then INIT with counter = 0.
- Reset mid-operation:
  - Any state returns to the reset values.
  - A pending resp_valid is dropped.
  - The sweep restarts from address 0.
- Simultaneous req_valid and reset: reset wins, no fire.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum {INIT, RUN, FLUSH_WAIT};
  - requester index constants REQ_REFILL = 0, REQ_CORE = 1;
  - a function for lane-to-bit-range width checks.
- One sub-module, rr_arb2: two-input round-robin grant with pointer register.
  - Inputs: clock, reset, valid[1:0], enable.
  - Outputs: grant[1:0] (one-hot or zero).
  - Pointer updates on fire.

Test Plan:
- Reset release, no requests, ADDR_W = 9 -> mem_en = 1, mem_wmode = 1 at addr 0..511 on 512 consecutive cycles, all-ones mask, zero data; init_done rises on cycle 512; req_ready = 0 before that.
- After init: port 1 writes addr 0x1A5, data 0xDEAD…BEEF, full mask; next cycle port 1 reads 0x1A5 -> resp_valid[1] one cycle after the read fire, resp_rdata = 0xDEAD…BEEF; resp_valid[0] stays 0.
- Both ports hold continuous reads for 6 cycles -> grants alternate 0,1,0,1,0,1; each resp_valid appears exactly one cycle after its fire.
- Masked write of 0xFF…FF with mask = 0x00000001 to addr 3, then read -> bits[7:0] = 0xFF and all other bits 0 (zeroed by the init sweep).
- flush_req during a read fire at cycle N -> response at N+1 delivered; req_ready = 0 at N+1 and N+2; the sweep restarts at addr 0; a read of the previously written addr after init_done returns 0.
- reset asserted at sweep addr 200 with a request pending -> all outputs at reset values next cycle; the sweep restarts at addr 0 and takes 512 full cycles.
